// File: rtl/key_debounce_filter.sv
// Push-button conditioner: two-flop synchroniser plus a per-key stability counter,
// producing a clean level and one-cycle press/release strobes for the key PIO.
module key_debounce_filter #(
  parameter int WIDTH           = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_clean,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam logic             IDLE      = ACTIVE_LOW;
  localparam logic [WIDTH-1:0] IDLE_VEC  = {WIDTH{IDLE}};
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= IDLE_VEC;
      sync2       <= IDLE_VEC;
      key_clean   <= IDLE_VEC;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        key_press[i]   <= 1'b0;
        key_release[i] <= 1'b0;
        if (sync2[i] == key_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_FINAL) begin
          // Level has been stable long enough: accept it and strobe its direction.
          key_clean[i]   <= sync2[i];
          cnt[i]         <= '0;
          key_press[i]   <= (sync2[i] != IDLE);
          key_release[i] <= (sync2[i] == IDLE);
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_filter.sv
// Directed bench for key_debounce_filter with DEBOUNCE_CYCLES=4, WIDTH=2, active-low keys.
module tb_key_debounce_filter;

  logic       clk;
  logic       reset_n;
  logic [1:0] key_raw;
  logic [1:0] key_clean;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int compared;
  int mismatched;

  key_debounce_filter #(
    .WIDTH(2),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .key_clean(key_clean),
    .key_press(key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] exp_clean,
                       input logic [1:0] exp_press, input logic [1:0] exp_release);
    compared++;
    assert (key_clean === exp_clean) else begin
      mismatched++;
      $error("FAIL %s key_clean: observed %b expected %b", tag, key_clean, exp_clean);
    end
    compared++;
    assert (key_press === exp_press) else begin
      mismatched++;
      $error("FAIL %s key_press: observed %b expected %b", tag, key_press, exp_press);
    end
    compared++;
    assert (key_release === exp_release) else begin
      mismatched++;
      $error("FAIL %s key_release: observed %b expected %b", tag, key_release, exp_release);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick_check(input string tag, input logic [1:0] exp_clean,
                            input logic [1:0] exp_press, input logic [1:0] exp_release);
    @(posedge clk);
    @(negedge clk);
    check(tag, exp_clean, exp_press, exp_release);
  endtask

  // Apply a new raw level and expect the transition on the 6th edge (k+5).
  task automatic settle(input string tag, input logic [1:0] raw, input logic [1:0] old_clean,
                        input logic [1:0] exp_press, input logic [1:0] exp_release);
    key_raw = raw;
    for (int e = 1; e <= 5; e++) tick_check({tag, "_wait"}, old_clean, 2'b00, 2'b00);
    tick_check({tag, "_edge"}, raw, exp_press, exp_release);
    tick_check({tag, "_after"}, raw, 2'b00, 2'b00);
  endtask

  logic [8:0] bounce;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    key_raw    = 2'b11;
    #23;
    check("in_reset", 2'b11, 2'b00, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    for (int e = 0; e < 50; e++) tick_check("idle", 2'b11, 2'b00, 2'b00);

    settle("press0", 2'b10, 2'b11, 2'b01, 2'b00);
    settle("release0", 2'b11, 2'b10, 2'b00, 2'b01);

    // Three-cycle low glitch reaches cnt = D-1 but must not transition.
    key_raw = 2'b10;
    for (int e = 1; e <= 3; e++) tick_check("glitch_low", 2'b11, 2'b00, 2'b00);
    key_raw = 2'b11;
    for (int e = 1; e <= 10; e++) tick_check("glitch_after", 2'b11, 2'b00, 2'b00);

    // Full latency again proves the counter was cleared by the glitch.
    settle("press0_again", 2'b10, 2'b11, 2'b01, 2'b00);
    settle("release0_again", 2'b11, 2'b10, 2'b00, 2'b01);

    // Bounce on key 1: pattern 0,1,0,0,1,0,0,0,0; final run starts at edge 6, press at edge 11.
    bounce = 9'b000010010;
    for (int e = 1; e <= 12; e++) begin
      key_raw = {(e <= 9) ? bounce[e-1] : 1'b0, 1'b1};
      if (e < 11)       tick_check("bounce_wait", 2'b11, 2'b00, 2'b00);
      else if (e == 11) tick_check("bounce_press", 2'b01, 2'b10, 2'b00);
      else              tick_check("bounce_after", 2'b01, 2'b00, 2'b00);
    end

    settle("press_both", 2'b00, 2'b01, 2'b01, 2'b00);
    settle("release_both", 2'b11, 2'b00, 2'b00, 2'b11);

    // Reset mid-count: cnt[0] is 2 after the 4th edge.
    key_raw = 2'b10;
    for (int e = 1; e <= 4; e++) tick_check("pre_reset", 2'b11, 2'b00, 2'b00);
    reset_n = 1'b0;
    #1;
    check("async_reset", 2'b11, 2'b00, 2'b00);
    @(negedge clk);
    check("reset_held", 2'b11, 2'b00, 2'b00);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) tick_check("post_reset_wait", 2'b11, 2'b00, 2'b00);
    tick_check("post_reset_press", 2'b10, 2'b01, 2'b00);
    tick_check("post_reset_after", 2'b10, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce_filter.md
Name: key_debounce_filter

Overview:
- Conditions raw push-button inputs before they reach the key PIO `in_port`.
- Per bit: two-flop synchroniser, then a saturating stability counter. Only levels stable for DEBOUNCE_CYCLES consecutive clocks propagate to `key_clean`.
- Also emits one-cycle press/release strobes for the edge-capture/IRQ logic.
- Sits between the board key pins and the Avalon PIO slave, in the same clk domain as the PIO.

Parameters:
- WIDTH, 2: number of keys.
- CNT_W, 16: stability counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new level (1 ms at 50 MHz). Legal range >= 1.
- ACTIVE_LOW, 1: 1 = key pressed drives 0, idle level 1; 0 = inverse.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- key_raw, input, WIDTH: asynchronous raw key pins.
- key_clean, output, WIDTH: debounced level; drives PIO `in_port`.
- key_press, output, WIDTH: one-cycle strobe per bit when clean moves idle->pressed.
- key_release, output, WIDTH: one-cycle strobe per bit when clean moves pressed->idle.

Behaviour:
- IDLE = ACTIVE_LOW ? 1 : 0, applied per bit.
- Reset (asynchronous, reset_n = 0):
  - sync1, sync2 and key_clean = {WIDTH{IDLE}}.
  - All counters = 0; key_press = key_release = 0.
  - Takes effect immediately, including mid-count; in-progress counts are discarded.
- Synchroniser: sync1 <= key_raw; sync2 <= sync1. No logic between the stages.
- Per bit i, evaluated each clock, registered:
  - sync2[i] == key_clean[i]: cnt[i] <= 0. No strobe.
  - sync2[i] != key_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != key_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: key_clean[i] <= sync2[i]; cnt[i] <= 0; strobe for that direction asserted this same edge.
- Any cycle where sync2 returns to key_clean before the count completes clears cnt. Glitches shorter than DEBOUNCE_CYCLES never reach key_clean.
- Latency: a stable raw level first captured into sync1 at edge k appears on key_clean at edge k+1+DEBOUNCE_CYCLES.
  - Strobes are registered and asserted on that same edge.
  - Strobes are high for exactly one cycle, then low the next edge unless another transition completes.
- Strobe direction:
  - key_press[i] = 1 only when key_clean[i] changes IDLE -> !IDLE.
  - key_release[i] = 1 only when key_clean[i] changes !IDLE -> IDLE.
  - key_press[i] and key_release[i] are never both 1.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous strobes.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Outputs are registered only; no combinational path from key_raw to any output.

Test Plan (bench uses DEBOUNCE_CYCLES=4, WIDTH=2, ACTIVE_LOW=1):
- Reset release, key_raw=2'b11 held -> key_clean=2'b11, key_press=key_release=0 for 50 cycles.
- key_raw[0] 1->0 captured into sync1 at edge k and held -> key_clean=2'b10 at edge k+5; key_press=2'b01 for exactly that cycle; key_release stays 0.
- key_raw[0] pulses low for 3 cycles, then high -> key_clean stays 2'b11; no strobes; cnt[0] returns to 0.
- Bounce: key_raw[1] pattern 0,1,0,0,1,0,0,0,0 (then held 0) -> single key_press[1] pulse, 5 edges after the final stable run starts in sync1; no intermediate strobes.
- Both keys released together from 2'b00 to 2'b11 -> key_clean=2'b11 and key_release=2'b11 on the same edge; key_press=0.
- reset_n asserted for 1 cycle while cnt[0]=2 mid-press -> immediate key_clean=2'b11 and cnt=0. After release, with key_raw[0] still 0, the press completes a full 1+DEBOUNCE_CYCLES edges after the first post-reset sync1 capture.
